div_clk_checker: RTL and testbench
==================================

DIV_CLK_CHECKER -- requirements
Module: div_clk_checker

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on div_in (minimum 2).
REQ-002 Parameter LOCK_CNT, default 4, consecutive good periods required to assert locked (1..15).
REQ-003 Port clk  input  1  reference clock; the only clock; all state on its rising edge.
REQ-004 Port rstn  input  1  asynchronous active-low reset.
REQ-005 Port div_in  input  1  divided clock under test; treated as asynchronous to clk.
REQ-006 Port en  input  1  checker enable; level-sensitive.
REQ-007 Port cfg_div  input  5  expected divide ratio N; valid range 2..31.
REQ-008 Port clr_err  input  1  single-cycle clear of err_sticky.
REQ-009 Port meas_valid  output  1  one-cycle pulse: a new measurement is present on meas_period/meas_high.
REQ-010 Port meas_period  output  6  clk cycles between the last two detected rising edges of div_in.
REQ-011 Port meas_high  output  6  clk cycles div_in was sampled high within that period.
REQ-012 Port locked  output  1  LOCK_CNT consecutive good periods seen; no error since.
REQ-013 Port err_pulse  output  1  one-cycle pulse per detected error.
REQ-014 Port err_sticky  output  1  set by err_pulse, cleared by clr_err or reset.

Function
REQ-015 div_in SHALL pass through SYNC_STAGES flops; rise = synced 1 and previous synced 0, detected one cycle after the last sync stage.
REQ-016 FSM states: IDLE, ACQ, MEAS, LOCK.
REQ-017 IDLE -> ACQ when en=1 and cfg_div in 2..31; any state -> IDLE when en=0 or cfg_div outside 2..31.
REQ-018 ACQ: wait for first rise; on rise clear counters, go to MEAS; no measurement is reported.
REQ-019 Period counter SHALL count cycles since the previous rise, saturating at 63; high counter counts cycles with synced=1 in the same window, saturating at 63.
REQ-020 On each rise in MEAS/LOCK: meas_period = cycles since previous rise, meas_high = high count for that window, meas_valid = 1 in the following cycle; counters restart for the new window.
REQ-021 Period good iff meas_period == N and meas_high is floor(N/2) or ceil(N/2).
REQ-022 MEAS: good-period counter increments per good period; reaching LOCK_CNT -> LOCK with locked=1 in the same cycle as meas_valid; a bad period resets the good count to 0 and stays in MEAS with no error pulse.
REQ-023 LOCK: a bad period SHALL assert err_pulse with meas_valid, clear locked, and go to MEAS with good count 0.
REQ-024 Timeout: in MEAS or LOCK, period counter reaching 2*N without a rise SHALL assert err_pulse only if in LOCK, and go to ACQ in all cases; locked clears.
REQ-025 cfg_div change while not IDLE SHALL force ACQ next cycle with locked=0 and no error.
REQ-026 clr_err in the same cycle as err_pulse: set wins; err_sticky stays 1.
REQ-027 Leaving to IDLE: locked=0; meas_period/meas_high hold last values; err_sticky holds.

Reset
REQ-028 rstn low SHALL asynchronously force: state IDLE, sync flops 0, all counters 0, meas_period=0, meas_high=0, meas_valid=0, locked=0, err_pulse=0, err_sticky=0.
REQ-029 Reset release SHALL be followed by an ACQ phase before any measurement; no output pulses in the first cycle after release.

Structure
REQ-030 Package div_chk_pkg SHALL hold the state enum, CNT_W=6, CFG_W=5, and a function giving floor/ceil(N/2).
REQ-031 Synchronizer SHALL be sub-module div_sync (parameter SYNC_STAGES, async active-low reset to 0).
REQ-032 No other clock, no derived clocks, no latches.

Verification
REQ-033 cfg_div=9, en=1, div_in = 50%-duty /9 clock (4.5-cycle high, AND of pos/neg phases) -> meas_period=9, meas_high 4 or 5 each period, locked=1 at the 4th meas_valid.
REQ-034 Locked at N=9, inject one 10-cycle period -> err_pulse with that meas_valid (meas_period=10), locked=0, relock after 4 further good periods, err_sticky=1 until clr_err.
REQ-035 Locked at N=9, hold div_in low -> err_pulse when period counter reaches 18, state ACQ, locked=0.
REQ-036 cfg_div=4, div_in duty 1/4 (high 1 cycle) -> no lock, no err_pulse, meas_high=1 reported each period.
REQ-037 Change cfg_div 9->8 while locked -> locked=0 next cycle, no err_pulse; with /8 input, locked after 4 periods.
REQ-038 Assert rstn low mid-period while locked -> all outputs 0 immediately; after release, first meas_valid only after two rises.

Source files
------------

// File: rtl/div_chk_pkg.sv
// Shared types and helpers for the divided-clock checker.
// Holds the FSM state encoding, counter/config widths and the duty-window helper.
package div_chk_pkg;

  localparam int CNT_W = 6;
  localparam int CFG_W = 5;

  typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCK} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] hi;
  } half_t;

  // floor(N/2) and ceil(N/2): the acceptable high-count window for a ratio N
  function automatic half_t half_of(input logic [CFG_W-1:0] n);
    half_t h;
    h.lo = CNT_W'(n >> 1);
    h.hi = CNT_W'(n >> 1) + CNT_W'(n[0]);
    return h;
  endfunction

endpackage

// File: rtl/div_sync.sv
// Multi-flop synchronizer bringing div_in into the clk domain.
// Latency SYNC_STAGES cycles; no flow control.
module div_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stg <= '0;
    else       stg <= {stg[SYNC_STAGES-2:0], d};
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/div_clk_checker.sv
// Measures period/high time of a divided clock against cfg_div and tracks lock/errors.
// Measurement reported one cycle after the synced rise; no backpressure, pulses are fire-and-forget.
module div_clk_checker
  import div_chk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             div_in,
  input  logic             en,
  input  logic [CFG_W-1:0] cfg_div,
  input  logic             clr_err,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic             sync_q, sync_d, rise;
  logic [CFG_W-1:0] cfg_q;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [3:0]       good_cnt;
  logic             cfg_ok, cfg_chg, abort, active;
  logic             timeout, meas_evt, period_ok, lock_hit, err_set;
  half_t            half;

  div_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (div_in),
    .q    (sync_q)
  );

  assign rise      = sync_q & ~sync_d;
  assign cfg_ok    = (cfg_div >= CFG_W'(2));
  assign cfg_chg   = (state != IDLE) && (cfg_div != cfg_q);
  assign abort     = !en || !cfg_ok || cfg_chg;
  assign active    = (state == MEAS) || (state == LOCK);
  assign half      = half_of(cfg_div);
  assign period_ok = (period_cnt == CNT_W'(cfg_div)) &&
                     ((high_cnt == half.lo) || (high_cnt == half.hi));
  // a rise on the 2N-th cycle still counts as an edge, not a timeout
  assign timeout   = active && !rise && (period_cnt == {cfg_div, 1'b0});
  assign meas_evt  = active && rise && !abort;
  assign lock_hit  = period_ok && ((good_cnt + 4'd1) == LOCK_TGT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en || !cfg_ok) begin
      state_nxt = IDLE;
    end else if (cfg_chg) begin
      state_nxt = ACQ;
    end else begin
      case (state)
        IDLE: state_nxt = ACQ;
        ACQ:  if (rise) state_nxt = MEAS;
        MEAS: begin
          if (timeout)                   state_nxt = ACQ;
          else if (meas_evt && lock_hit) state_nxt = LOCK;
        end
        LOCK: begin
          if (timeout)                     state_nxt = ACQ;
          else if (meas_evt && !period_ok) state_nxt = MEAS;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    err_set = 1'b0;
    if ((state == LOCK) && !abort) err_set = timeout || (meas_evt && !period_ok);
  end

  assign locked = (state == LOCK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_d      <= 1'b0;
      cfg_q       <= '0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      good_cnt    <= '0;
      meas_valid  <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      sync_d <= sync_q;
      cfg_q  <= cfg_div;

      // the rise cycle itself is the first cycle (and first high sample) of the new window
      if (state == IDLE) begin
        period_cnt <= '0;
        high_cnt   <= '0;
      end else if (rise) begin
        period_cnt <= CNT_W'(1);
        high_cnt   <= CNT_W'(1);
      end else begin
        if (period_cnt != '1)          period_cnt <= period_cnt + CNT_W'(1);
        if (sync_q && high_cnt != '1)  high_cnt   <= high_cnt + CNT_W'(1);
      end

      if (state_nxt != MEAS) good_cnt <= '0;
      else if (meas_evt)     good_cnt <= period_ok ? good_cnt + 4'd1 : 4'd0;

      meas_valid <= meas_evt;
      if (meas_evt) begin
        meas_period <= period_cnt;
        meas_high   <= high_cnt;
      end

      err_pulse <= err_set;
      // a clear arriving alongside the error pulse loses to the set
      if (err_set)                    err_sticky <= 1'b1;
      else if (clr_err && !err_pulse) err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker: lock, bad period, timeout, duty, cfg change, reset.
module tb_div_clk_checker;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       div_in = 1'b0;
  logic       en = 1'b0;
  logic [4:0] cfg_div = 5'd0;
  logic       clr_err = 1'b0;
  logic       meas_valid;
  logic [5:0] meas_period;
  logic [5:0] meas_high;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;

  int n_checks = 0;
  int n_pass = 0;
  int err_cnt = 0;
  int rise_cnt = 0;
  int gen_period = 9;
  int gen_high_half = 9;
  int extra_req = 0;
  int extra_done = 0;
  bit gen_on = 1'b0;

  div_clk_checker #(.SYNC_STAGES(2), .LOCK_CNT(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .div_in      (div_in),
    .en          (en),
    .cfg_div     (cfg_div),
    .clr_err     (clr_err),
    .meas_valid  (meas_valid),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  // divided-clock source: edges placed 1 time unit after a rising clk edge, high for gen_high_half half-cycles
  always begin : p_gen
    int lowd;
    wait (gen_on);
    @(posedge clk);
    #1;
    while (gen_on) begin
      div_in = 1'b1;
      rise_cnt++;
      #(gen_high_half * 5);
      div_in = 1'b0;
      lowd = gen_period * 10 - gen_high_half * 5;
      if (extra_done != extra_req) begin
        lowd = lowd + 10;
        extra_done = extra_req;
      end
      #(lowd);
    end
  end

  always @(negedge clk) if (err_pulse === 1'b1) err_cnt++;

  task automatic wait_meas(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (meas_valid !== 1'b1 && k < 200);
    n_checks++;
    if (meas_valid !== 1'b1) $display("FAIL %s: meas_valid=%b after %0d cycles, want 1", tag, meas_valid, k);
    else n_pass++;
  endtask

  task automatic do_reset();
    gen_on = 1'b0; en = 1'b0; clr_err = 1'b0; cfg_div = 5'd0;
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_gen(input int n, input int high_half);
    cfg_div = 5'(n); en = 1'b1;
    gen_period = n; gen_high_half = high_half; gen_on = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({meas_valid, meas_period, meas_high, locked, err_pulse, err_sticky} !== 16'h0)
      $display("FAIL reset_outputs: got %h want 0", {meas_valid, meas_period, meas_high, locked, err_pulse, err_sticky});
    else n_pass++;
    cfg_div = 5'd9; en = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({meas_valid, err_pulse, locked} !== 3'b000) $display("FAIL reset_release: got %b want 000", {meas_valid, err_pulse, locked});
    else n_pass++;
  endtask

  task automatic test_lock9();
    int e0;
    do_reset();
    e0 = err_cnt;
    start_gen(9, 9);
    for (int i = 1; i <= 4; i++) begin
      wait_meas("lock9_wait");
      n_checks++;
      if (meas_period !== 6'd9) $display("FAIL lock9_period: got %0d want 9", meas_period); else n_pass++;
      n_checks++;
      if (meas_high !== 6'd4 && meas_high !== 6'd5) $display("FAIL lock9_high: got %0d want 4 or 5", meas_high); else n_pass++;
      n_checks++;
      if (locked !== (i == 4)) $display("FAIL lock9_locked meas %0d: got %b want %b", i, locked, (i == 4)); else n_pass++;
    end
    n_checks++;
    if (err_cnt !== e0) $display("FAIL lock9_no_err: got %0d err pulses want 0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_bad_period();
    int e0;
    e0 = err_cnt;
    extra_req++;
    wait_meas("bad_wait");
    n_checks++;
    if (meas_period !== 6'd10) $display("FAIL bad_period: got %0d want 10", meas_period); else n_pass++;
    n_checks++;
    if ({err_pulse, locked} !== 2'b10) $display("FAIL bad_err_lock: got %b want 10", {err_pulse, locked}); else n_pass++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++;
    if (err_sticky !== 1'b1) $display("FAIL bad_set_wins: err_sticky got %b want 1", err_sticky); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      wait_meas("relock_wait");
      n_checks++;
      if ({meas_period, locked} !== {6'd9, (i == 4)}) $display("FAIL relock meas %0d: period %0d locked %b", i, meas_period, locked);
      else n_pass++;
    end
    n_checks++;
    if (err_sticky !== 1'b1) $display("FAIL sticky_hold: got %b want 1", err_sticky); else n_pass++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++;
    if (err_sticky !== 1'b0) $display("FAIL sticky_clear: got %b want 0", err_sticky); else n_pass++;
    n_checks++;
    if (err_cnt - e0 !== 1) $display("FAIL bad_err_count: got %0d want 1", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_timeout();
    int k;
    wait_meas("timeout_sync");
    gen_on = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (err_pulse !== 1'b1 && k < 40);
    n_checks++;
    if (k !== 18) $display("FAIL timeout_cycles: err_pulse after %0d cycles want 18", k); else n_pass++;
    n_checks++;
    if ({locked, err_sticky} !== 2'b01) $display("FAIL timeout_state: locked,sticky got %b want 01", {locked, err_sticky}); else n_pass++;
  endtask

  task automatic test_quarter();
    int e0;
    do_reset();
    e0 = err_cnt;
    start_gen(4, 2);
    for (int i = 1; i <= 5; i++) begin
      wait_meas("quarter_wait");
      n_checks++;
      if ({meas_period, meas_high, locked} !== {6'd4, 6'd1, 1'b0})
        $display("FAIL quarter meas %0d: period %0d high %0d locked %b want 4 1 0", i, meas_period, meas_high, locked);
      else n_pass++;
    end
    n_checks++;
    if (err_cnt !== e0) $display("FAIL quarter_no_err: got %0d want 0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_cfg_change();
    int e0;
    do_reset();
    start_gen(9, 9);
    repeat (4) wait_meas("cfg_lock_wait");
    e0 = err_cnt;
    cfg_div = 5'd8; gen_period = 8; gen_high_half = 8;
    @(negedge clk);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL cfg_unlock: got %b want 0", locked); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      wait_meas("cfg8_wait");
      n_checks++;
      if ({meas_period, meas_high, locked} !== {6'd8, 6'd4, (i == 4)})
        $display("FAIL cfg8 meas %0d: period %0d high %0d locked %b", i, meas_period, meas_high, locked);
      else n_pass++;
    end
    n_checks++;
    if (err_cnt !== e0) $display("FAIL cfg_no_err: got %0d want 0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rc0;
    do_reset();
    start_gen(9, 9);
    repeat (4) wait_meas("rst_lock_wait");
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({meas_valid, meas_period, meas_high, locked, err_pulse, err_sticky} !== 16'h0)
      $display("FAIL midrst_outputs: got %h want 0", {meas_valid, meas_period, meas_high, locked, err_pulse, err_sticky});
    else n_pass++;
    #105;
    rc0 = rise_cnt;
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({meas_valid, err_pulse} !== 2'b00) $display("FAIL midrst_first_cycle: got %b want 00", {meas_valid, err_pulse}); else n_pass++;
    wait_meas("midrst_wait");
    n_checks++;
    if (rise_cnt - rc0 !== 2) $display("FAIL midrst_rises: first meas after %0d rises want 2", rise_cnt - rc0); else n_pass++;
    n_checks++;
    if (meas_period !== 6'd9) $display("FAIL midrst_period: got %0d want 9", meas_period); else n_pass++;
  endtask

  task automatic test_disable();
    int mv;
    do_reset();
    start_gen(9, 9);
    repeat (4) wait_meas("dis_lock_wait");
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (locked !== 1'b0) $display("FAIL dis_unlock: got %b want 0", locked); else n_pass++;
    mv = 0;
    repeat (30) begin
      @(negedge clk);
      if (meas_valid === 1'b1) mv++;
    end
    n_checks++;
    if (mv !== 0) $display("FAIL dis_no_meas: got %0d pulses want 0", mv); else n_pass++;
    n_checks++;
    if ({meas_period, meas_high} !== {6'd9, 6'd4}) $display("FAIL dis_hold: period %0d high %0d want 9 4", meas_period, meas_high);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock9();
    test_bad_period();
    test_timeout();
    test_quarter();
    test_cfg_change();
    test_reset_mid();
    test_disable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
